// File: rtl/wb_sched_pkg.sv
// rtl/wb_sched_pkg.sv - shared types and latency helpers for the result-tag scheduler
package wb_sched_pkg;

  // Default tag and latency field widths of the scheduler.
  localparam int WB_PRF_WIDTH = 6;
  localparam int WB_LAT_WIDTH = 3;

  // Deepest latency a LAT_WIDTH-bit field can express (zero is not a legal latency).
  function automatic int wb_max_lat(input int lat_width);
    return (1 << lat_width) - 1;
  endfunction

  localparam int MAX_LAT = wb_max_lat(WB_LAT_WIDTH);

  // One reservation on a lane's tag bus; an empty slot always carries tag 0.
  typedef struct packed {
    logic                    valid;
    logic [WB_PRF_WIDTH-1:0] prd;
  } wb_slot_t;

endpackage

// File: rtl/wb_lane.sv
// rtl/wb_lane.sv - one issue lane: slot shift register, reservation, conflict detect, lat_free
module wb_lane
  import wb_sched_pkg::*;
#(
  parameter int  PRF_WIDTH = 6,
  parameter int  LAT_WIDTH = 3,
  parameter bit  EARLY_EN  = 1'b0,
  localparam int N_LAT     = wb_max_lat(LAT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 issue_v,
  input  logic                 issue_prd_v,
  input  logic [PRF_WIDTH-1:0] issue_prd,
  input  logic [LAT_WIDTH-1:0] issue_lat,
  output logic [N_LAT-1:0]     lat_free,
  output logic                 tag_v,
  output logic [PRF_WIDTH-1:0] tag,
  output logic                 early_v,
  output logic [PRF_WIDTH-1:0] early_tag,
  output logic                 conflict
);

  // The slot struct is sized by the package; a lane built with another tag width is unusable.
  if (PRF_WIDTH != WB_PRF_WIDTH) begin : g_width_check
    $error("wb_lane: PRF_WIDTH must equal WB_PRF_WIDTH");
  end

  // slot[k] is the reservation that will drive the tag bus k-1 cycles from now.
  wb_slot_t             slot     [1:N_LAT];
  wb_slot_t             slot_nxt [1:N_LAT];
  logic [N_LAT:1]       busy;
  logic [LAT_WIDTH-1:0] lat_eff;
  logic                 want;
  logic                 hit;

  // A zero latency is illegal; it is folded onto the shortest legal latency.
  always_comb begin
    lat_eff = (issue_lat == '0) ? LAT_WIDTH'(1) : issue_lat;
  end

  // busy[L]: an issue with latency L now would land on an already reserved slot after the shift.
  always_comb begin
    busy = '0;
    for (int k = 1; k < N_LAT; k++) begin
      busy[k] = slot[k+1].valid;
    end
  end

  assign lat_free = ~busy;

  // Tag 0 is always ready, so it never occupies the bus; flush drops same-cycle issues.
  always_comb begin
    want     = issue_v && issue_prd_v && (issue_prd != '0) && !flush;
    hit      = want && busy[lat_eff];
    conflict = hit;
  end

  // Shift every slot toward the bus and drop a winning reservation into its latency slot.
  always_comb begin
    for (int k = 1; k < N_LAT; k++) begin
      slot_nxt[k] = slot[k+1];
    end
    slot_nxt[N_LAT] = '0;
    if (want && !hit) begin
      slot_nxt[lat_eff] = {1'b1, WB_PRF_WIDTH'(issue_prd)};
    end
  end

  // Slot register; reset and flush both discard every pending reservation.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 1; k <= N_LAT; k++) begin
        slot[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= N_LAT; k++) begin
        slot[k] <= slot_nxt[k];
      end
    end
  end

  // Flag the illegal zero latency on any grant.
  always_ff @(posedge clk) begin
    if (!rst && issue_v) begin
      assert (issue_lat != '0)
        else $error("wb_lane: issue with zero latency");
    end
  end

  assign tag_v = slot[1].valid;
  assign tag   = PRF_WIDTH'(slot[1].prd);

  if (EARLY_EN && (N_LAT >= 2)) begin : g_early
    assign early_v   = slot[2].valid;
    assign early_tag = PRF_WIDTH'(slot[2].prd);
  end else begin : g_no_early
    assign early_v   = 1'b0;
    assign early_tag = '0;
  end

endmodule

// File: rtl/wb_tag_scheduler.sv
// rtl/wb_tag_scheduler.sv - per-lane result tag broadcast scheduler; WB_SPEC_WAKEUP_EN enables early wakeup
module wb_tag_scheduler
  import wb_sched_pkg::*;
#(
  parameter int  ISSUE_NUM = 4,
  parameter int  PRF_WIDTH = 6,
  parameter int  LAT_WIDTH = 3,
  localparam int N_LAT     = wb_max_lat(LAT_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [ISSUE_NUM-1:0]           issue_v,
  input  logic [ISSUE_NUM-1:0]           issue_prd_v,
  input  logic [ISSUE_NUM*PRF_WIDTH-1:0] issue_prd,
  input  logic [ISSUE_NUM*LAT_WIDTH-1:0] issue_lat,
  output logic [ISSUE_NUM*N_LAT-1:0]     lat_free,
  output logic [ISSUE_NUM-1:0]           wb_tag_v,
  output logic [ISSUE_NUM*PRF_WIDTH-1:0] wb_tag,
  output logic [ISSUE_NUM-1:0]           spec_tag_v,
  output logic [ISSUE_NUM*PRF_WIDTH-1:0] spec_tag,
  output logic                           conflict_err
);

`ifdef WB_SPEC_WAKEUP_EN
  localparam bit SPEC_EN = 1'b1;
`else
  localparam bit SPEC_EN = 1'b0;
`endif

  logic [ISSUE_NUM-1:0] lane_conflict;

  for (genvar j = 0; j < ISSUE_NUM; j++) begin : g_lane
    wb_lane #(
      .PRF_WIDTH (PRF_WIDTH),
      .LAT_WIDTH (LAT_WIDTH),
      .EARLY_EN  (SPEC_EN)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .issue_v     (issue_v[j]),
      .issue_prd_v (issue_prd_v[j]),
      .issue_prd   (issue_prd[j*PRF_WIDTH +: PRF_WIDTH]),
      .issue_lat   (issue_lat[j*LAT_WIDTH +: LAT_WIDTH]),
      .lat_free    (lat_free[j*N_LAT +: N_LAT]),
      .tag_v       (wb_tag_v[j]),
      .tag         (wb_tag[j*PRF_WIDTH +: PRF_WIDTH]),
      .early_v     (spec_tag_v[j]),
      .early_tag   (spec_tag[j*PRF_WIDTH +: PRF_WIDTH]),
      .conflict    (lane_conflict[j])
    );
  end

  // Sticky conflict flag; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_err <= 1'b0;
    end else if (|lane_conflict) begin
      conflict_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_tag_scheduler.sv
// tb/tb_wb_tag_scheduler.sv - self-checking bench for wb_tag_scheduler
module tb_wb_tag_scheduler;

  localparam int IN = 4;
  localparam int PW = 6;
  localparam int LW = 3;
  localparam int NL = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [IN-1:0]     issue_v;
  logic [IN-1:0]     issue_prd_v;
  logic [IN*PW-1:0]  issue_prd;
  logic [IN*LW-1:0]  issue_lat;
  logic [IN*NL-1:0]  lat_free;
  logic [IN-1:0]     wb_tag_v;
  logic [IN*PW-1:0]  wb_tag;
  logic [IN-1:0]     spec_tag_v;
  logic [IN*PW-1:0]  spec_tag;
  logic              conflict_err;

  wb_tag_scheduler #(.ISSUE_NUM(IN), .PRF_WIDTH(PW), .LAT_WIDTH(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .issue_v      (issue_v),
    .issue_prd_v  (issue_prd_v),
    .issue_prd    (issue_prd),
    .issue_lat    (issue_lat),
    .lat_free     (lat_free),
    .wb_tag_v     (wb_tag_v),
    .wb_tag       (wb_tag),
    .spec_tag_v   (spec_tag_v),
    .spec_tag     (spec_tag),
    .conflict_err (conflict_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int lane;
    int prd;
  } pend_t;

  typedef struct {
    int lane;
    bit v;
    bit pv;
    int prd;
    int lat;
    bit exp_err;
  } vec_t;

  pend_t sb[$];
  vec_t  tbl[20];
  int    cyc;
  int    n_assert;
  int    n_fail;
  bit    exp_conflict;
  logic [IN*NL-1:0] all_free;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rst         = 1'b0;
    flush       = 1'b0;
    issue_v     = '0;
    issue_prd_v = '0;
    issue_prd   = '0;
    issue_lat   = '0;
  endtask

  task automatic set_issue(input int lane, input bit v, input bit pv, input int prd, input int lat);
    issue_v[lane]              = v;
    issue_prd_v[lane]          = pv;
    issue_prd[lane*PW +: PW]   = PW'(prd);
    issue_lat[lane*LW +: LW]   = LW'(lat);
  endtask

  // Expected effect of the coming clock edge, taken from the inputs now driven.
  task automatic model_edge();
    if (rst) begin
      sb.delete();
      exp_conflict = 1'b0;
    end else if (flush) begin
      sb.delete();
    end else begin
      for (int j = 0; j < IN; j++) begin
        int  p;
        int  l;
        bit  taken;
        p = int'(issue_prd[j*PW +: PW]);
        l = int'(issue_lat[j*LW +: LW]);
        if (l == 0) l = 1;
        if (issue_v[j] && issue_prd_v[j] && p != 0) begin
          taken = 1'b0;
          foreach (sb[i]) if (sb[i].lane == j && sb[i].due == cyc + l) taken = 1'b1;
          if (taken) exp_conflict = 1'b1;
          else sb.push_back('{due: cyc + l, lane: j, prd: p});
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [IN-1:0]    ev;
    logic [IN*PW-1:0] et;
    logic [IN-1:0]    esv;
    logic [IN*PW-1:0] est;
    logic [IN*NL-1:0] elf;
    ev  = '0;
    et  = '0;
    esv = '0;
    est = '0;
    elf = '1;
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        ev[sb[i].lane]            = 1'b1;
        et[sb[i].lane*PW +: PW]   = PW'(sb[i].prd);
      end
`ifdef WB_SPEC_WAKEUP_EN
      if (sb[i].due == cyc + 1) begin
        esv[sb[i].lane]           = 1'b1;
        est[sb[i].lane*PW +: PW]  = PW'(sb[i].prd);
      end
`endif
      for (int l = 1; l < NL; l++) begin
        if (sb[i].due == cyc + l) elf[sb[i].lane*NL + l - 1] = 1'b0;
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) sb.delete(i);
    end
    chk("wb_tag_v", 64'(wb_tag_v), 64'(ev));
    chk("wb_tag", 64'(wb_tag), 64'(et));
    chk("spec_tag_v", 64'(spec_tag_v), 64'(esv));
    chk("spec_tag", 64'(spec_tag), 64'(est));
    chk("lat_free", 64'(lat_free), 64'(elf));
    chk("conflict_err", 64'(conflict_err), 64'(exp_conflict));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    n_assert     = 0;
    n_fail       = 0;
    cyc          = 0;
    exp_conflict = 1'b0;
    all_free     = '1;
    clear_inputs();

    // lane, v, pv, prd, lat, expected conflict_err after the vector
    tbl[0]  = '{0, 1, 1, 5, 3, 0};
    tbl[1]  = '{0, 0, 0, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 1, 0};
    tbl[4]  = '{2, 1, 1, 0, 4, 0};
    tbl[5]  = '{3, 1, 0, 33, 2, 0};
    tbl[6]  = '{3, 0, 1, 44, 2, 0};
    tbl[7]  = '{1, 1, 1, 63, 7, 0};
    tbl[8]  = '{2, 1, 1, 17, 1, 0};
    tbl[9]  = '{3, 1, 1, 20, 5, 0};
    tbl[10] = '{3, 1, 1, 21, 6, 0};
    tbl[11] = '{0, 1, 1, 7, 2, 0};
    for (int i = 12; i < 20; i++) tbl[i] = '{0, 0, 0, 0, 1, 0};

    // Reset, then idle.
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_lat_free", 64'(lat_free), 64'(all_free));
    chk("rst_wb_tag_v", 64'(wb_tag_v), 64'd0);
    chk("rst_wb_tag", 64'(wb_tag), 64'd0);
    chk("rst_conflict", 64'(conflict_err), 64'd0);

    // Table-driven single-lane issues, including tag 0 and no-destination grants.
    for (int i = 0; i < 20; i++) begin
      set_issue(tbl[i].lane, tbl[i].v, tbl[i].pv, tbl[i].prd, tbl[i].lat);
      tick();
      chk("tbl_conflict", 64'(conflict_err), 64'(tbl[i].exp_err));
    end

    // All lanes issue L=1 every cycle with distinct tags.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < IN; j++) set_issue(j, 1, 1, 1 + j*8 + i, 1);
      tick();
    end
    tick();
    chk("l1_no_conflict", 64'(conflict_err), 64'd0);

    // Back-to-back L=4 then L=3 on lane 1: second one collides and is dropped.
    c0 = cyc;
    set_issue(1, 1, 1, 9, 4);
    tick();
    set_issue(1, 1, 1, 12, 3);
    tick();
    chk("conf_sticky", 64'(conflict_err), 64'd1);
    tick();
    tick();
    chk("conf_cycle", 64'(cyc - c0), 64'd4);
    chk("conf_tag_v", 64'(wb_tag_v[1]), 64'd1);
    chk("conf_tag", 64'(wb_tag[1*PW +: PW]), 64'd9);
    for (int i = 0; i < 4; i++) tick();

    // Reservations pending at L=2..7, then flush together with a new issue.
    set_issue(0, 1, 1, 40, 7);
    set_issue(1, 1, 1, 41, 6);
    set_issue(2, 1, 1, 42, 5);
    set_issue(3, 1, 1, 43, 4);
    tick();
    set_issue(0, 1, 1, 44, 3);
    set_issue(1, 1, 1, 45, 2);
    tick();
    flush = 1'b1;
    set_issue(2, 1, 1, 50, 2);
    tick();
    chk("flush_tag_v", 64'(wb_tag_v), 64'd0);
    chk("flush_lat_free", 64'(lat_free), 64'(all_free));
    chk("flush_conflict", 64'(conflict_err), 64'd1);
    for (int i = 0; i < 8; i++) tick();

    // Reset mid-operation drops reservations and clears the sticky flag.
    set_issue(3, 1, 1, 60, 5);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_conflict", 64'(conflict_err), 64'd0);
    chk("midrst_lat_free", 64'(lat_free), 64'(all_free));
    for (int i = 0; i < 7; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_tag_scheduler.md
# wb_tag_scheduler

Result-tag broadcast scheduler between the issue arbiter and the wakeup logic. Granted instructions with a destination physical register reserve a slot on the result tag bus of their issue lane, `L` cycles ahead, where `L` is the functional-unit latency. Each cycle the block drives the tag bus that wakes dependent issue-queue entries. It also exports per-lane, per-latency availability masks so the arbiter never grants two results onto the same lane in the same cycle.

## Interface
Parameters:
- `ISSUE_NUM`, 4, number of issue lanes / tag buses
- `PRF_WIDTH`, 6, physical register tag width
- `LAT_WIDTH`, 3, latency field width; `MAX_LAT = 2**LAT_WIDTH - 1` (7)

Ports:
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  reset; synchronous, active-high
- `flush`  in  1  pipeline flush; drops all pending reservations
- `issue_v`  in  ISSUE_NUM  lane j issues an instruction this cycle (arbiter grant)
- `issue_prd_v`  in  ISSUE_NUM  issued instruction writes a physical register
- `issue_prd`  in  ISSUE_NUM*PRF_WIDTH  destination tag, lane j at `[j*PRF_WIDTH +: PRF_WIDTH]`
- `issue_lat`  in  ISSUE_NUM*LAT_WIDTH  result latency, 1..MAX_LAT
- `lat_free`  out  ISSUE_NUM*MAX_LAT  bit `j*MAX_LAT+(L-1)` set means lane j may issue with latency L this cycle
- `wb_tag_v`  out  ISSUE_NUM  tag bus j valid
- `wb_tag`  out  ISSUE_NUM*PRF_WIDTH  tag bus j tag
- `spec_tag_v`  out  ISSUE_NUM  early (speculative) wakeup valid, one cycle ahead
- `spec_tag`  out  ISSUE_NUM*PRF_WIDTH  early wakeup tag
- `conflict_err`  out  1  sticky: an issue hit an occupied slot

## Operation
- Each lane holds a slot shift register `slot[1..MAX_LAT]`, each slot = {valid, prd}.
- Every edge: `slot[k] <= slot[k+1]` for k < MAX_LAT; `slot[MAX_LAT] <= invalid`.
- Reservation: on an edge with `issue_v[j] && issue_prd_v[j] && prd != 0`, write {1, prd} into `slot[L]`, overriding the shift value.
- Tag 0 is architecturally always ready. An issue with `prd == 0` or `issue_prd_v == 0` reserves nothing and broadcasts nothing.
- `issue_lat == 0` is illegal and is treated as L = 1. A simulation assertion fires on it.
- Outputs are driven directly from registers: `wb_tag_v[j] = slot[1].valid`, `wb_tag[j] = slot[1].prd`. When invalid, the tag reads 0, never a stale value.
- `lat_free[j][L] = !slot[L+1].valid` for L < MAX_LAT. `lat_free[j][MAX_LAT] = 1`.
- Conflict (issue with `slot[L+1].valid` set):
  - the existing reservation is kept;
  - the new one is dropped;
  - `conflict_err` sets and holds until `rst`.
- `flush`:
  - clears every slot on that edge;
  - same-cycle issues are dropped (flush has priority);
  - outputs are all invalid on the following cycle;
  - `conflict_err` is unaffected.
- Lanes are fully independent. There is no cross-lane arbitration.

## Timing
- Issue at cycle t with latency L: `wb_tag_v` high in cycle t+L, for exactly one cycle.
- Back-to-back issues on one lane with latencies L and L-1 in consecutive cycles collide. The second issue sees `lat_free[L-1] = 0`.
- `lat_free` reflects the current slot state combinationally. It is valid in the issue cycle with zero latency.
- Reset values:
  - all slots invalid;
  - `wb_tag_v = 0`, `wb_tag = 0`;
  - `spec_tag_v = 0`, `spec_tag = 0`;
  - `lat_free` all ones;
  - `conflict_err = 0`.
- Reset mid-operation discards all reservations on that edge, identically to flush, and additionally clears `conflict_err`.

## Configuration
- `WB_SPEC_WAKEUP_EN` defined:
  - `spec_tag_v[j] = slot[2].valid`, `spec_tag[j] = slot[2].prd`;
  - this is an early wakeup one cycle before `wb_tag`, enabling back-to-back dependent issue;
  - an L=1 issue produces no spec pulse.
- `WB_SPEC_WAKEUP_EN` undefined: `spec_tag_v` and `spec_tag` are tied to 0. Slot storage is unchanged.

## Structure
- Shared package `wb_sched_pkg`:
  - `MAX_LAT` localparam derivation;
  - `wb_slot_t` typedef {valid, prd}.
- Sub-module `wb_lane`: one slot shift register with reservation, conflict detect and per-lane `lat_free`. The top instantiates `ISSUE_NUM` lanes and ORs their conflict pulses into `conflict_err`.

## Test plan
- Reset, then idle: `lat_free` = all ones, `wb_tag_v` = 0, `conflict_err` = 0.
- Lane 0 issues prd=5, L=3 at cycle 10:
  - `wb_tag_v[0]` = 1 with tag 5 only in cycle 13;
  - `lat_free[0][2]` = 0 in cycle 11;
  - with the macro defined, `spec_tag_v[0]` = 1 with tag 5 in cycle 12.
- Lane 1 issues prd=9, L=4 at cycle 0, then prd=12, L=3 at cycle 1:
  - second issue is dropped and `conflict_err` = 1;
  - only tag 9 is broadcast, in cycle 4.
- Issues with prd=0 and with `issue_prd_v` = 0: no reservation, no broadcast, `lat_free` unchanged.
- All lanes issue L=1 every cycle with distinct tags: each tag appears on its own lane exactly one cycle later, with no conflicts.
- Reservations pending at L=2..7 when `flush` is asserted together with a new issue: all `wb_tag_v` = 0 from the next cycle, `lat_free` all ones, `conflict_err` unchanged.
